fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Read-side consumer for the dual-clock FIFO, running entirely in the read clock domain. Pops words from the FIFO's first-word-fall-through read port and re-emits them as a valid/ready stream framed into fixed-length bursts with a last marker. Bursts start only when the FIFO reports at least ALMOST_GAP+1 words. A starvation timer drains stragglers as single-word bursts so no data stays stranded.

## Interface
- DATESIZE, 8, data word width; must match the FIFO.
- BURST_LEN, 4, beats per normal burst; 2..16; must be ≤ FIFO ALMOST_GAP+1.
- TIMEOUT, 16, IDLE cycles with data present but `almost_empty`=1 before flush starts; ≥2.
- rclk  in  1  read-domain clock; one clock only.
- rrst_n  in  1  asynchronous, active-low reset; shared with the FIFO read side.
- drain_en  in  1  1 = reader may start bursts/flush; 0 = finish the current burst, then hold in IDLE.
- rdata  in  DATESIZE  FIFO head word, valid whenever `rempty`=0.
- rempty  in  1  FIFO empty flag.
- almost_empty  in  1  FIFO almost-empty flag.
- rinc  out  1  pop strobe; combinational from registered state and FIFO flags only.
- m_data  out  DATESIZE  stream data.
- m_valid  out  1  stream valid.
- m_last  out  1  last beat of burst; qualified by m_valid.
- m_ready  in  1  stream ready.
- busy  out  1  FSM not in IDLE, or buffer non-empty.

## Operation
- FSM states: IDLE, BURST, FLUSH.
  - IDLE:
    - settle counter `idle_cnt` saturates at 2; it is cleared on IDLE entry.
    - go to BURST when drain_en=1, almost_empty=0 and idle_cnt=2. The settle window absorbs the one-cycle staleness of almost_empty.
    - else go to FLUSH when drain_en=1 and starve_cnt=TIMEOUT.
  - BURST:
    - pop when rempty=0 and buf_cnt<2; `beat` counts pops 0..BURST_LEN-1.
    - word with beat=BURST_LEN-1 is tagged last=1, then go to IDLE.
    - if rempty=1 mid-burst, stall without leaving BURST. No short bursts.
  - FLUSH:
    - pop when rempty=0 and buf_cnt<2; every word is tagged last=1 (1-beat bursts).
    - go to IDLE when rempty=1, or almost_empty=0, or drain_en=0. Any of these blocks the pop that cycle.
- starve_cnt, width clog2(TIMEOUT+1):
  - increments in IDLE while rempty=0, almost_empty=1, drain_en=1; saturates at TIMEOUT.
  - cleared otherwise, and on leaving IDLE.
- rinc = (state∈{BURST,FLUSH}) & ~rempty & (buf_cnt<2) & pop-permitted. It never depends on m_ready.
- Output buffer: 2-entry skid holding {last, data}.
  - push = rinc; pop = m_valid & m_ready; both in the same cycle allowed.
  - m_valid = buf_cnt≠0; m_data/m_last = head entry.
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
- drain_en falling during BURST does not truncate the burst. Framing is always preserved.

## Timing
- Reset (async assert, release synchronous to rclk):
  - state=IDLE, buf_cnt=0, beat=0, idle_cnt=0, starve_cnt=0.
  - m_valid=0, m_last=0, m_data=0, busy=0, rinc=0.
- Pop at cycle N → word on m_data with m_valid=1 at N+1.
- Steady state with m_ready=1 and FIFO deep: 1 word/cycle; buf_cnt holds at 1.
- Minimum gap between consecutive normal bursts: the last pop, plus 2 IDLE settle cycles. The first pop of the next burst occurs in the cycle after the IDLE→BURST transition.
- m_ready=0 stalls: at most 2 more pops (buffer fills), then rinc=0 until space frees.
- Reset mid-burst discards buffered words and the partial burst. This is acceptable because the FIFO read side resets on the same rrst_n.

## Structure
- Shared package `fifo_rd_pkg`: state encodings (IDLE=2'd0, BURST=2'd1, FLUSH=2'd2) and the clog2 helper function.
- Sub-module `fifo_rd_skid`: 2-entry {last, data} buffer with push/pop/count. The FSM and counters stay in the top module.

## Test plan
- 8 words preloaded (almost_empty=0), m_ready=1, drain_en=1 → two bursts of 4; m_last on beats 4 and 8; 2 idle cycles between bursts; data order preserved.
- 2 words preloaded (almost_empty=1) → after 16 IDLE cycles, FLUSH emits 2 words, each with m_last=1; then IDLE; starve_cnt=0.
- Burst in progress; m_ready held 0 for 10 cycles → exactly 2 pops then rinc=0; m_data stable; on release, all 4 beats delivered with m_last on beat 4.
- FIFO runs empty after beat 2 of a burst; refilled 5 cycles later → FSM stays in BURST; beats 3-4 follow; no early m_last.
- drain_en dropped on beat 2 → burst completes to 4 beats, then IDLE with rinc=0 while data remains.
- rrst_n asserted with 2 words buffered → m_valid=0, m_last=0, busy=0 immediately; state=IDLE.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side burst reader: FSM encodings and a
// constant-width helper.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry {last, data} output buffer between the FIFO pop strobe and the
// valid/ready stream; the head entry is presented on the stream outputs.
module fifo_rd_skid #(
  parameter int unsigned DATESIZE = 8
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                push,
  input  logic                push_last,
  input  logic [DATESIZE-1:0] push_data,
  input  logic                pop,
  output logic [1:0]          cnt,
  output logic                head_last,
  output logic [DATESIZE-1:0] head_data
);

  logic [DATESIZE:0] ent0;
  logic [DATESIZE:0] ent1;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= {push_last, push_data};
          else             ent1 <= {push_last, push_data};
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // pop implies a non-empty buffer; count is unchanged
          if (cnt == 2'd1) begin
            ent0 <= {push_last, push_data};
          end else begin
            ent0 <= ent1;
            ent1 <= {push_last, push_data};
          end
        end
        default: ;
      endcase
    end
  end

  assign {head_last, head_data} = ent0;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-domain consumer for the dual-clock FIFO: pops first-word-fall-through
// words and re-emits them as fixed-length bursts, flushing stragglers on timeout.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATESIZE  = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                drain_en,
  input  logic [DATESIZE-1:0] rdata,
  input  logic                rempty,
  input  logic                almost_empty,
  output logic                rinc,
  output logic [DATESIZE-1:0] m_data,
  output logic                m_valid,
  output logic                m_last,
  input  logic                m_ready,
  output logic                busy
);

  localparam int unsigned SW = clog2(TIMEOUT + 1);
  localparam int unsigned BW = clog2(BURST_LEN);
  localparam logic [SW-1:0] STARVE_MAX = SW'(TIMEOUT);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST_LEN - 1);

  rd_state_e      state, state_nxt;
  logic [BW-1:0]  beat, beat_nxt;
  logic [1:0]     idle_cnt, idle_cnt_nxt;
  logic [SW-1:0]  starve_cnt, starve_cnt_nxt;
  logic [1:0]     buf_cnt;
  logic           push_last;
  logic           buf_pop;
  logic           buf_room;

  assign buf_room = (buf_cnt < 2'd2);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state      <= IDLE;
      beat       <= '0;
      idle_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      beat       <= beat_nxt;
      idle_cnt   <= idle_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    rinc      = 1'b0;
    push_last = 1'b0;
    case (state)
      IDLE: begin
        if (drain_en && !almost_empty && idle_cnt == 2'd2) state_nxt = BURST;
        else if (drain_en && starve_cnt == STARVE_MAX)     state_nxt = FLUSH;
      end
      BURST: begin
        if (!rempty && buf_room) begin
          rinc = 1'b1;
          if (beat == BEAT_LAST) begin
            push_last = 1'b1;
            beat_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (rempty || !almost_empty || !drain_en) begin
          state_nxt = IDLE;
        end else if (buf_room) begin
          rinc      = 1'b1;
          push_last = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Counting starts on the edge that enters IDLE, so idle_cnt reaches 2
    // in the second IDLE cycle and a new burst can begin right after it.
    idle_cnt_nxt = '0;
    if (state_nxt == IDLE)
      idle_cnt_nxt = (idle_cnt == 2'd2) ? idle_cnt : idle_cnt + 2'd1;

    starve_cnt_nxt = '0;
    if (state == IDLE && state_nxt == IDLE && !rempty && almost_empty && drain_en)
      starve_cnt_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
  end

  assign m_valid = (buf_cnt != 2'd0);
  assign buf_pop = m_valid & m_ready;
  assign busy    = (state != IDLE) | m_valid;

  fifo_rd_skid #(.DATESIZE(DATESIZE)) u_skid (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .push      (rinc),
    .push_last (push_last),
    .push_data (rdata),
    .pop       (buf_pop),
    .cnt       (buf_cnt),
    .head_last (m_last),
    .head_data (m_data)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a small FWFT FIFO model on the
// read side and a beat recorder on the output stream.
module tb_fifo_burst_reader;

  localparam int unsigned DW  = 8;
  localparam int unsigned GAP = 3;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          drain_en = 1'b0;
  logic          m_ready = 1'b0;
  logic          ae_force = 1'b0;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic          almost_empty;
  logic          rinc;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          busy;

  logic [DW-1:0] mem [0:63];
  int unsigned   wptr = 0;
  int unsigned   rptr = 0;
  int unsigned   fcnt;
  int unsigned   cyc = 0;

  int            n_checks = 0;
  int            n_errors = 0;

  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  int unsigned   got_c [$];
  int unsigned   pops = 0;

  fifo_burst_reader #(
    .DATESIZE  (DW),
    .BURST_LEN (4),
    .TIMEOUT   (16)
  ) dut (
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .drain_en     (drain_en),
    .rdata        (rdata),
    .rempty       (rempty),
    .almost_empty (almost_empty),
    .rinc         (rinc),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .busy         (busy)
  );

  always #5 rclk = ~rclk;

  always @(posedge rclk) cyc <= cyc + 1;

  always_comb begin
    fcnt         = wptr - rptr;
    rempty       = (fcnt == 0);
    almost_empty = ae_force ? 1'b0 : (fcnt <= GAP);
    rdata        = mem[rptr % 64];
  end

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)   rptr <= wptr;
    else if (rinc) rptr <= rptr + 1;
  end

  always @(negedge rclk) begin
    if (rrst_n) begin
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        got_c.push_back(cyc);
      end
      if (rinc) pops++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) mem[(wptr + i) % 64] = base + DW'(i);
    wptr = wptr + n;
  endtask

  task automatic clear_got();
    got_d.delete();
    got_l.delete();
    got_c.delete();
    pops = 0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (got_d.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (got_d.size() < n) chk({tag, "_beats_timeout"}, got_d.size(), n);
  endtask

  task automatic wait_pops(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (pops < n && k < budget) begin
      tick();
      k++;
    end
    if (pops < n) chk({tag, "_pops_timeout"}, pops, n);
  endtask

  task automatic check_beats(input string tag, input int n, input logic [DW-1:0] base,
                             input logic [15:0] last_mask);
    chk({tag, "_count"}, got_d.size(), n);
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_d[i], base + DW'(i));
      chk($sformatf("%s_last%0d", tag, i), got_l[i], last_mask[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned c0;

    // reset state
    cycles(3);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rinc", rinc, 0);
    chk("rst_state", dut.state, 0);
    rrst_n = 1'b1;
    tick();
    chk("rst_starve", dut.starve_cnt, 0);
    chk("rst_beat", dut.beat, 0);

    // two back-to-back bursts from 8 preloaded words
    clear_got();
    push_words(8, 8'h10);
    drain_en = 1'b1;
    m_ready  = 1'b1;
    wait_beats("t1", 8, 100);
    check_beats("t1", 8, 8'h10, 16'h0088);
    if (got_c.size() >= 8) begin
      chk("t1_inburst_gap", got_c[1] - got_c[0], 1);
      chk("t1_burst_gap", got_c[4] - got_c[3], 3);
    end
    cycles(5);
    chk("t1_state", dut.state, 0);
    chk("t1_busy", busy, 0);

    // starvation flush of 2 stragglers
    clear_got();
    c0 = cyc;
    push_words(2, 8'h20);
    wait_beats("t2", 2, 60);
    check_beats("t2", 2, 8'h20, 16'h0003);
    if (got_c.size() >= 2) begin
      chk("t2_latency", got_c[0] - c0, 18);
      chk("t2_spacing", got_c[1] - got_c[0], 1);
    end
    cycles(3);
    chk("t2_state", dut.state, 0);
    chk("t2_starve", dut.starve_cnt, 0);
    chk("t2_busy", busy, 0);

    // backpressure: buffer fills after 2 pops, head stays stable
    clear_got();
    m_ready = 1'b0;
    push_words(4, 8'h30);
    wait_pops("t3", 2, 20);
    cycles(10);
    chk("t3_pops_stalled", pops, 2);
    chk("t3_rinc", rinc, 0);
    chk("t3_valid", m_valid, 1);
    chk("t3_data_hold", m_data, 8'h30);
    chk("t3_last_hold", m_last, 0);
    chk("t3_state", dut.state, 1);
    m_ready = 1'b1;
    wait_beats("t3", 4, 40);
    check_beats("t3", 4, 8'h30, 16'h0008);
    chk("t3_pops", pops, 4);

    // FIFO runs dry mid-burst, refilled later
    clear_got();
    drain_en = 1'b0;
    cycles(2);
    push_words(2, 8'h40);
    ae_force = 1'b1;
    drain_en = 1'b1;
    wait_pops("t4", 2, 20);
    ae_force = 1'b0;
    cycles(5);
    chk("t4_state_stall", dut.state, 1);
    chk("t4_partial_count", got_d.size(), 2);
    if (got_l.size() >= 2) begin
      chk("t4_no_early_last0", got_l[0], 0);
      chk("t4_no_early_last1", got_l[1], 0);
    end
    chk("t4_rinc_dry", rinc, 0);
    push_words(2, 8'h42);
    wait_beats("t4", 4, 30);
    check_beats("t4", 4, 8'h40, 16'h0008);
    cycles(5);
    chk("t4_state_end", dut.state, 0);

    // drain_en drops mid-burst: burst completes, then holds
    clear_got();
    push_words(8, 8'h50);
    wait_pops("t5", 2, 20);
    drain_en = 1'b0;
    wait_beats("t5", 4, 30);
    cycles(10);
    check_beats("t5", 4, 8'h50, 16'h0008);
    chk("t5_state", dut.state, 0);
    chk("t5_rinc", rinc, 0);
    chk("t5_data_left", rempty, 0);
    chk("t5_pops", pops, 4);

    // reset with two buffered words
    clear_got();
    m_ready  = 1'b0;
    drain_en = 1'b1;
    wait_pops("t6", 2, 20);
    cycles(2);
    chk("t6_pre_valid", m_valid, 1);
    chk("t6_pre_bufcnt", dut.buf_cnt, 2);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("t6_valid", m_valid, 0);
    chk("t6_last", m_last, 0);
    chk("t6_data", m_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rinc", rinc, 0);
    chk("t6_state", dut.state, 0);
    drain_en = 1'b0;
    tick();
    rrst_n = 1'b1;
    cycles(3);
    chk("t6_fifo_empty", rempty, 1);
    chk("t6_post_valid", m_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
